div_arbiter: RTL and testbench
==============================

# div_arbiter

Shares one iterative `divider_top` between up to NREQ independent requesters in the acoustic localisation pipeline, for example distance, R, x/y position and 2D projection calculators. It arbitrates requests round-robin, latches operands, and issues a one-cycle `data_rdy` pulse to the divider. It waits for `res_rdy`, then returns quotient and remainder to the granted requester. Divide-by-zero is intercepted before issue, and a hung divider is covered by a watchdog.

## Interface
- NREQ, 4: number of requesters (2..8).
- N, 32: dividend/quotient width (signed).
- M, 32: divisor/remainder width (signed).
- TIMEOUT, 64: max cycles in WAIT before abort (≥ divider latency + 2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- req  in  NREQ  per-requester request level
- req_dividend  in  NREQ*N  packed operands, slice i = [i*N +: N]
- req_divisor  in  NREQ*M  packed operands, slice i = [i*M +: M]
- ack  out  NREQ  one-hot, 1-cycle pulse: operands of requester i latched
- rsp_valid  out  NREQ  one-hot, 1-cycle pulse: result for requester i
- rsp_merchant  out  N  quotient, valid with rsp_valid
- rsp_remainder  out  M  remainder, valid with rsp_valid
- rsp_err  out  2  00 ok, 01 divide-by-zero, 10 timeout
- busy  out  1  high in any state except IDLE
- div_data_rdy  out  1  start pulse to divider
- div_dividend  out  N  held stable from issue until response
- div_divisor  out  M  held stable from issue until response
- div_res_rdy  in  1  divider result strobe
- div_merchant  in  N  divider quotient
- div_remainder  in  M  divider remainder

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req bit is set, the round-robin grant g is the first set bit searching from last_grant+1 (mod NREQ).
  - Latch the g operands, pulse ack[g], and update last_grant := g.
  - If the divisor is 0, go to RESP with err=01, merchant = 0x7FFF_FFFF (dividend ≥ 0) or 0x8000_0000 (dividend < 0), remainder = dividend. The divider is not started.
  - Otherwise go to ISSUE.
- ISSUE: div_data_rdy=1 for exactly this cycle, clear the watchdog, go to WAIT.
- WAIT: on div_res_rdy, capture merchant and remainder, set err=00, and go to RESP.
  - Otherwise increment the watchdog. At TIMEOUT−1, set merchant=0, remainder=0, err=10, and go to RESP.
  - If div_res_rdy and the timeout occur in the same cycle, res_rdy wins.
- RESP: rsp_valid[g]=1 for one cycle, then go to IDLE.
- Requesters keep req high until ack. Dropping req before ack withdraws the request, with no ack and no response. Requesters may change operands the cycle after ack. The next request may be raised after rsp_valid.
- div_res_rdy outside WAIT is ignored (late result after a timeout).
- Grant is evaluated only in IDLE. Requests arriving during a transaction wait. Fairness: a requester waits at most NREQ−1 transactions.
- Reset values: all outputs 0, state IDLE, last_grant = NREQ−1 (so requester 0 wins first), watchdog 0.
- Reset mid-operation returns to IDLE immediately, with no rsp_valid. The divider shares rst_n.

## Timing
- All outputs are registered.
- Request seen in IDLE at edge 0: ack and div_data_rdy are high in cycle 1.
- Divider strobe: with div_res_rdy sampled high in cycle k, rsp_valid is high in cycle k+1.
- Total latency is divider latency + 3 cycles.
- Divide-by-zero: ack in cycle 1, rsp_valid in cycle 2.
- Timeout: rsp_valid in cycle TIMEOUT+2.
- Back-to-back: minimum spacing between ack pulses is divider latency + 3 cycles. IDLE is always visited for one cycle between transactions.
- ack and rsp_valid are never high in the same cycle.

## Structure
- Package div_arb_pkg holds:
  - state encoding (2 bits);
  - error codes ERR_OK, ERR_DIV0, ERR_TMO;
  - saturation constants for divide-by-zero.
- Sub-module rr_arbiter: parameterised NREQ. It takes req and last_grant and produces a one-hot grant plus grant_idx, and is purely combinational. The FSM, watchdog and operand/result registers sit in div_arbiter.

## Test plan
- Single request: req[0], 1000/7 → ack[0] in cycle 1; later rsp_valid[0] with merchant=142, remainder=6, err=00.
- Contention: req=4'b1111 held → ack order 0,1,2,3; after a new req[0]|req[3] with last_grant=3 → requester 0 next, then 3.
- Divide by zero: req[2], −50/0 → no div_data_rdy; rsp_valid[2] in cycle 2 with merchant=0x8000_0000, remainder=−50, err=01.
- Timeout: divider stub never asserts res_rdy, TIMEOUT=16 → rsp_valid with err=10 in cycle 18. A late res_rdy pulse in IDLE is ignored, with no extra rsp_valid.
- Withdrawal and reset: req[1] dropped while requester 0 is serviced → no ack[1]. rst_n low during WAIT → all outputs 0, state IDLE, and the next request is granted to requester 0 first.
- Signed operands: −340/93 → merchant=−3, remainder=−61 passed through unchanged.

Source files
------------

// File: rtl/div_arb_pkg.sv
// Shared encodings for the divider arbiter: FSM states, error codes and
// divide-by-zero saturation patterns (MSB-aligned, sliced to width by users).
package div_arb_pkg;

   localparam int unsigned ST_W = 2;
   localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
   localparam logic [ST_W-1:0] ST_ISSUE = 2'd1;
   localparam logic [ST_W-1:0] ST_WAIT  = 2'd2;
   localparam logic [ST_W-1:0] ST_RESP  = 2'd3;

   localparam int unsigned ERR_W = 2;
   localparam logic [ERR_W-1:0] ERR_OK   = 2'b00;
   localparam logic [ERR_W-1:0] ERR_DIV0 = 2'b01;
   localparam logic [ERR_W-1:0] ERR_TMO  = 2'b10;

   // Take the top N bits to get the saturated quotient for any N <= 64
   localparam int unsigned SAT_W = 64;
   localparam logic [SAT_W-1:0] SAT_POS = 64'h7FFF_FFFF_FFFF_FFFF;
   localparam logic [SAT_W-1:0] SAT_NEG = 64'h8000_0000_0000_0000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit searching upward from
// last_grant+1, wrapping modulo NREQ.
module rr_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   last_grant,
   output logic [NREQ-1:0] grant_c,
   output logic [IW-1:0]   grant_idx_c
);

   int unsigned idx;
   logic        found;

   always_comb begin
      grant_c     = '0;
      grant_idx_c = '0;
      found       = 1'b0;
      idx         = 0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         idx = (32'(last_grant) + k) % NREQ;
         if (!found && req[IW'(idx)]) begin
            found                = 1'b1;
            grant_c[IW'(idx)]    = 1'b1;
            grant_idx_c          = IW'(idx);
         end
      end
   end

endmodule

// File: rtl/div_arbiter.sv
// Shares one iterative divider between NREQ requesters: round-robin grant,
// divide-by-zero interception before issue, and a watchdog on the wait.
module div_arbiter
   import div_arb_pkg::*;
#(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned N       = 32,
   parameter int unsigned M       = 32,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*N-1:0] req_dividend,
   input  logic [NREQ*M-1:0] req_divisor,
   output logic [NREQ-1:0]   ack,
   output logic [NREQ-1:0]   rsp_valid,
   output logic [N-1:0]      rsp_merchant,
   output logic [M-1:0]      rsp_remainder,
   output logic [1:0]        rsp_err,
   output logic              busy,
   output logic              div_data_rdy,
   output logic [N-1:0]      div_dividend,
   output logic [M-1:0]      div_divisor,
   input  logic              div_res_rdy,
   input  logic [N-1:0]      div_merchant,
   input  logic [M-1:0]      div_remainder
);

   localparam int unsigned     IW       = $clog2(NREQ);
   localparam int unsigned     WW       = $clog2(TIMEOUT);
   localparam logic [WW-1:0]   WD_LAST  = WW'(TIMEOUT - 1);
   localparam logic [N-1:0]    DIV0_POS = SAT_POS[SAT_W-1 -: N];
   localparam logic [N-1:0]    DIV0_NEG = SAT_NEG[SAT_W-1 -: N];
   localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

   logic [ST_W-1:0]  state_q, state_d;
   logic [IW-1:0]    last_grant_q, last_grant_d;
   logic [WW-1:0]    wd_q, wd_d;
   logic [NREQ-1:0]  ack_q, ack_d, rsp_valid_q, rsp_valid_d;
   logic [N-1:0]     merchant_q, merchant_d, dividend_q, dividend_d;
   logic [M-1:0]     remainder_q, remainder_d, divisor_q, divisor_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic             busy_q, busy_d, data_rdy_q, data_rdy_d;

   logic [NREQ-1:0]  grant_c;
   logic [IW-1:0]    grant_idx_c;
   logic [N-1:0]     dvd_arr [NREQ];
   logic [M-1:0]     dvs_arr [NREQ];
   logic [N-1:0]     sel_dvd_c;
   logic [M-1:0]     sel_dvs_c;

   for (genvar i = 0; i < NREQ; i++) begin : g_slice
      assign dvd_arr[i] = req_dividend[i*N +: N];
      assign dvs_arr[i] = req_divisor[i*M +: M];
   end

   assign sel_dvd_c = dvd_arr[grant_idx_c];
   assign sel_dvs_c = dvs_arr[grant_idx_c];

   rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
      .req         (req),
      .last_grant  (last_grant_q),
      .grant_c     (grant_c),
      .grant_idx_c (grant_idx_c)
   );

   // Next-state and registered-output logic; last_grant doubles as the owner index
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      wd_d         = wd_q;
      dividend_d   = dividend_q;
      divisor_d    = divisor_q;
      merchant_d   = merchant_q;
      remainder_d  = remainder_q;
      err_d        = err_q;
      ack_d        = '0;
      rsp_valid_d  = '0;
      data_rdy_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (|req) begin
               ack_d        = grant_c;
               last_grant_d = grant_idx_c;
               dividend_d   = sel_dvd_c;
               divisor_d    = sel_dvs_c;
               if (sel_dvs_c == '0) begin
                  state_d     = ST_RESP;
                  err_d       = ERR_DIV0;
                  merchant_d  = sel_dvd_c[N-1] ? DIV0_NEG : DIV0_POS;
                  remainder_d = M'($signed(sel_dvd_c));
               end else begin
                  state_d    = ST_ISSUE;
                  data_rdy_d = 1'b1;
               end
            end
         end
         ST_ISSUE: begin
            wd_d    = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (div_res_rdy) begin
               merchant_d  = div_merchant;
               remainder_d = div_remainder;
               err_d       = ERR_OK;
               rsp_valid_d = ONE_HOT0 << last_grant_q;
               state_d     = ST_RESP;
            end else if (wd_q == WD_LAST) begin
               merchant_d  = '0;
               remainder_d = '0;
               err_d       = ERR_TMO;
               rsp_valid_d = ONE_HOT0 << last_grant_q;
               state_d     = ST_RESP;
            end else begin
               wd_d = wd_q + WW'(1);
            end
         end
         ST_RESP: begin
            // Divide-by-zero enters RESP with ack still high, so it emits one cycle later
            if (rsp_valid_q != '0) begin
               state_d = ST_IDLE;
            end else begin
               rsp_valid_d = ONE_HOT0 << last_grant_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         last_grant_q <= IW'(NREQ - 1);
         wd_q         <= '0;
         dividend_q   <= '0;
         divisor_q    <= '0;
         merchant_q   <= '0;
         remainder_q  <= '0;
         err_q        <= ERR_OK;
         ack_q        <= '0;
         rsp_valid_q  <= '0;
         data_rdy_q   <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         wd_q         <= wd_d;
         dividend_q   <= dividend_d;
         divisor_q    <= divisor_d;
         merchant_q   <= merchant_d;
         remainder_q  <= remainder_d;
         err_q        <= err_d;
         ack_q        <= ack_d;
         rsp_valid_q  <= rsp_valid_d;
         data_rdy_q   <= data_rdy_d;
         busy_q       <= busy_d;
      end
   end

   assign ack           = ack_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_merchant  = merchant_q;
   assign rsp_remainder = remainder_q;
   assign rsp_err       = err_q;
   assign busy          = busy_q;
   assign div_data_rdy  = data_rdy_q;
   assign div_dividend  = dividend_q;
   assign div_divisor   = divisor_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Scoreboard bench for div_arbiter: directed requests with hand-computed
// results, a 3-cycle divider stub, and a monitor that pops expectations.
module tb_div_arbiter;

   localparam int unsigned NREQ    = 4;
   localparam int unsigned N       = 32;
   localparam int unsigned M       = 32;
   localparam int unsigned TIMEOUT = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NREQ-1:0]   req = '0;
   logic [NREQ*N-1:0] req_dividend = '0;
   logic [NREQ*M-1:0] req_divisor = '0;
   logic [NREQ-1:0]   ack, rsp_valid;
   logic [N-1:0]      rsp_merchant;
   logic [M-1:0]      rsp_remainder;
   logic [1:0]        rsp_err;
   logic              busy, div_data_rdy;
   logic [N-1:0]      div_dividend;
   logic [M-1:0]      div_divisor;
   logic              div_res_rdy;
   logic [N-1:0]      div_merchant;
   logic [M-1:0]      div_remainder;

   typedef struct {
      int          idx;
      logic [31:0] q;
      logic [31:0] r;
      logic [1:0]  err;
      int          cyc;
   } rsp_t;
   typedef struct {
      int idx;
      int cyc;
   } ack_t;

   rsp_t rsp_q[$];
   ack_t ack_q[$];
   rsp_t er;
   ack_t ea;
   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   n_issue = 0;
   bit   hang = 1'b0;
   bit   late_tgl = 1'b0;

   div_arbiter #(.NREQ(NREQ), .N(N), .M(M), .TIMEOUT(TIMEOUT)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req           (req),
      .req_dividend  (req_dividend),
      .req_divisor   (req_divisor),
      .ack           (ack),
      .rsp_valid     (rsp_valid),
      .rsp_merchant  (rsp_merchant),
      .rsp_remainder (rsp_remainder),
      .rsp_err       (rsp_err),
      .busy          (busy),
      .div_data_rdy  (div_data_rdy),
      .div_dividend  (div_dividend),
      .div_divisor   (div_divisor),
      .div_res_rdy   (div_res_rdy),
      .div_merchant  (div_merchant),
      .div_remainder (div_remainder)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (div_data_rdy) n_issue <= n_issue + 1;

   initial begin
      #100000;
      $display("FAIL global_timeout: run did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Divider stub: result strobe two cycles after the start pulse is seen
   initial begin
      int                 cnt;
      bit                 late_seen;
      logic signed [31:0] sa, sb, q, r;
      cnt = 0; late_seen = 1'b0; q = '0; r = '0;
      div_res_rdy = 1'b0; div_merchant = '0; div_remainder = '0;
      forever begin
         @(negedge clk);
         div_res_rdy = 1'b0;
         if (!rst_n) begin
            cnt = 0;
         end else if (late_tgl != late_seen) begin
            late_seen     = late_tgl;
            div_merchant  = 32'hDEAD_BEEF;
            div_remainder = 32'h0000_5A5A;
            div_res_rdy   = 1'b1;
         end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               div_merchant  = q;
               div_remainder = r;
               div_res_rdy   = 1'b1;
            end
         end else if (div_data_rdy && !hang) begin
            sa  = div_dividend;
            sb  = div_divisor;
            q   = (sb == 0) ? 32'sd0 : sa / sb;
            r   = (sb == 0) ? 32'sd0 : sa % sb;
            cnt = 2;
         end
      end
   end

   // Monitor: pop and compare whenever the DUT presents ack or rsp_valid
   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         if (|ack || |rsp_valid)
            chk("ack_rsp_exclusive", 64'(|ack & |rsp_valid), 64'd0);
         if (|ack) begin
            if (ack_q.size() == 0) begin
               chk("unexpected_ack", 64'(ack), 64'd0);
            end else begin
               ea = ack_q.pop_front();
               chk("ack_onehot", 64'(ack), 64'(1) << ea.idx);
               if (ea.cyc >= 0) chk("ack_cycle", 64'(cyc), 64'(ea.cyc));
            end
         end
         if (|rsp_valid) begin
            if (rsp_q.size() == 0) begin
               chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
            end else begin
               er = rsp_q.pop_front();
               chk("rsp_onehot", 64'(rsp_valid), 64'(1) << er.idx);
               chk("rsp_merchant", 64'(rsp_merchant), 64'(er.q));
               chk("rsp_remainder", 64'(rsp_remainder), 64'(er.r));
               chk("rsp_err", 64'(rsp_err), 64'(er.err));
               if (er.cyc >= 0) chk("rsp_cycle", 64'(cyc), 64'(er.cyc));
            end
         end
      end
   end

   task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
      req_dividend[i*N +: N] = a;
      req_divisor[i*M +: M]  = b;
   endtask

   task automatic exp_ack(input int idx, input int c);
      ack_t e;
      e.idx = idx; e.cyc = c;
      ack_q.push_back(e);
   endtask

   task automatic exp_rsp(input int idx, input logic [31:0] q, input logic [31:0] r,
                          input logic [1:0] err, input int c);
      rsp_t e;
      e.idx = idx; e.q = q; e.r = r; e.err = err; e.cyc = c;
      rsp_q.push_back(e);
   endtask

   // Requester behaviour: hold req until its ack, then drop it
   task automatic wait_ack(input int idx);
      bit seen = 1'b0;
      for (int k = 0; k < 200 && !seen; k++) begin
         @(negedge clk);
         seen = ack[idx];
      end
      chk("ack_arrived", 64'(seen), 64'd1);
      req[idx] = 1'b0;
   endtask

   task automatic wait_rsp();
      bit seen = 1'b0;
      for (int k = 0; k < 200 && !seen; k++) begin
         @(negedge clk);
         seen = |rsp_valid;
      end
      chk("rsp_arrived", 64'(seen), 64'd1);
      @(negedge clk);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ack"}, 64'(ack), 64'd0);
      chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
      chk({tag, "_merchant"}, 64'(rsp_merchant), 64'd0);
      chk({tag, "_remainder"}, 64'(rsp_remainder), 64'd0);
      chk({tag, "_err"}, 64'(rsp_err), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_data_rdy"}, 64'(div_data_rdy), 64'd0);
      chk({tag, "_div_dividend"}, 64'(div_dividend), 64'd0);
      chk({tag, "_div_divisor"}, 64'(div_divisor), 64'd0);
   endtask

   initial begin
      int base;
      int n0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_busy", 64'(busy), 64'd0);

      // Contention with all four held: 0,1,2,3
      set_op(0, 32'd100, 32'd10);
      set_op(1, 32'hFFFF_FFF9, 32'd2);
      set_op(2, 32'd7, 32'hFFFF_FFFE);
      set_op(3, 32'd0, 32'd5);
      for (int k = 0; k < 4; k++) exp_ack(k, -1);
      exp_rsp(0, 32'd10, 32'd0, 2'b00, -1);
      exp_rsp(1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 2'b00, -1);
      exp_rsp(2, 32'hFFFF_FFFD, 32'd1, 2'b00, -1);
      exp_rsp(3, 32'd0, 32'd0, 2'b00, -1);
      req = 4'b1111;
      for (int k = 0; k < 4; k++) wait_ack(k);
      wait_rsp();

      // last_grant = 3: requester 0 then 3
      set_op(0, 32'd81, 32'd9);
      set_op(3, 32'd50, 32'd8);
      exp_ack(0, -1); exp_ack(3, -1);
      exp_rsp(0, 32'd9, 32'd0, 2'b00, -1);
      exp_rsp(3, 32'd6, 32'd2, 2'b00, -1);
      req = 4'b1001;
      wait_ack(0); wait_ack(3);
      wait_rsp();

      // Single request 1000/7 with exact latency
      set_op(0, 32'd1000, 32'd7);
      n0 = n_issue;
      req = 4'b0001;
      base = cyc + 1;
      exp_ack(0, base);
      exp_rsp(0, 32'd142, 32'd6, 2'b00, base + 3);
      wait_ack(0);
      wait_rsp();
      chk("single_issue_count", 64'(n_issue - n0), 64'd1);

      // Divide by zero, negative dividend
      set_op(2, 32'hFFFF_FFCE, 32'd0);
      n0 = n_issue;
      req = 4'b0100;
      base = cyc + 1;
      exp_ack(2, base);
      exp_rsp(2, 32'h8000_0000, 32'hFFFF_FFCE, 2'b01, base + 1);
      wait_ack(2);
      wait_rsp();
      chk("div0_neg_no_issue", 64'(n_issue - n0), 64'd0);

      // Divide by zero, positive dividend
      set_op(1, 32'd77, 32'd0);
      n0 = n_issue;
      req = 4'b0010;
      base = cyc + 1;
      exp_ack(1, base);
      exp_rsp(1, 32'h7FFF_FFFF, 32'd77, 2'b01, base + 1);
      wait_ack(1);
      wait_rsp();
      chk("div0_pos_no_issue", 64'(n_issue - n0), 64'd0);

      // Signed -340/93
      set_op(1, 32'hFFFF_FEAC, 32'd93);
      req = 4'b0010;
      base = cyc + 1;
      exp_ack(1, base);
      exp_rsp(1, 32'hFFFF_FFFD, 32'hFFFF_FFC3, 2'b00, base + 3);
      wait_ack(1);
      wait_rsp();

      // Hung divider: watchdog abort, then a late strobe in IDLE is ignored
      hang = 1'b1;
      set_op(3, 32'd5, 32'd5);
      req = 4'b1000;
      base = cyc + 1;
      exp_ack(3, base);
      exp_rsp(3, 32'd0, 32'd0, 2'b10, base + TIMEOUT + 1);
      wait_ack(3);
      wait_rsp();
      late_tgl = ~late_tgl;
      repeat (4) @(negedge clk);
      chk("late_strobe_busy", 64'(busy), 64'd0);
      hang = 1'b0;

      // Requester 1 withdraws while 0 is being serviced
      set_op(0, 32'd9, 32'd3);
      set_op(1, 32'd4, 32'd2);
      exp_ack(0, -1);
      exp_rsp(0, 32'd3, 32'd0, 2'b00, -1);
      req = 4'b0011;
      wait_ack(0);
      req[1] = 1'b0;
      wait_rsp();
      repeat (3) @(negedge clk);
      chk("withdraw_idle_busy", 64'(busy), 64'd0);

      // Reset during WAIT
      hang = 1'b1;
      set_op(2, 32'd1, 32'd1);
      exp_ack(2, -1);
      req = 4'b0100;
      wait_ack(2);
      repeat (3) @(negedge clk);
      chk("pre_reset_busy", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      chk_all_zero("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      hang = 1'b0;
      @(negedge clk);

      // last_grant back to NREQ-1: requester 0 before 3
      set_op(0, 32'd12, 32'd4);
      set_op(3, 32'd13, 32'd4);
      exp_ack(0, -1); exp_ack(3, -1);
      exp_rsp(0, 32'd3, 32'd0, 2'b00, -1);
      exp_rsp(3, 32'd3, 32'd1, 2'b00, -1);
      req = 4'b1001;
      wait_ack(0); wait_ack(3);
      wait_rsp();

      repeat (5) @(negedge clk);
      chk("ack_queue_drained", 64'(ack_q.size()), 64'd0);
      chk("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
